offchip_mem_model: RTL and testbench
====================================

OFFCHIP_MEM_MODEL -- requirements
Module: offchip_mem_model

Interface
REQ-001 Parameter MEMSIZE, default 64: bytes of modelled memory, 1..128.
REQ-002 Parameter BASE_ADDR, default 0: 7-bit address of byte 0.
REQ-003 Parameter READ_DELAY, default 2: read latency in cycles, 2..8.
REQ-004 Parameter WRITE_DELAY, default 1: write-ack latency in cycles, 1..8.
REQ-005 Port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port Mout_oe_ram, input, 2 bits: per-channel read enable.
REQ-008 Port Mout_we_ram, input, 2 bits: per-channel write enable.
REQ-009 Port Mout_addr_ram, input, 14 bits: channel c uses byte address [7c+6:7c].
REQ-010 Port Mout_Wdata_ram, input, 32 bits: channel c uses write data [16c+15:16c].
REQ-011 Port Mout_data_ram_size, input, 10 bits: channel c uses access size in bits [5c+4:5c].
REQ-012 Port M_Rdata_ram, output, 32 bits: channel c read data on [16c+15:16c].
REQ-013 Port M_DataRdy, output, 2 bits: per-channel access-complete strobe.
REQ-014 Port error, output, 1 bit: sticky protocol-violation flag.

Function
REQ-015 Hit(c): BASE_ADDR <= addr_c < BASE_ADDR+MEMSIZE; a miss has no effect, drives DataRdy_c=0 and samples read data 0.
REQ-016 Per-channel counter cnt_c: increments while an enabled access hits; wraps to 0 when it reaches its delay minus 1; forced to 0 when the channel is idle or misses.
REQ-017 Read: oe_c=1 with a hit in cycle 0 gives DataRdy_c=1 in cycle READ_DELAY-1 (combinationally from cnt_c==READ_DELAY-1).
REQ-018 Read data: {mem[addr+1], mem[addr]} is sampled every cycle into a READ_DELAY-1 stage shift pipeline; M_Rdata_ram slice c is the pipeline output; a byte beyond MEMSIZE reads as 0.
REQ-019 Holding oe_c with a hit yields one DataRdy_c pulse every READ_DELAY cycles.
REQ-020 Write: with we_c=1 and a hit, DataRdy_c=1 when cnt_c==WRITE_DELAY-1 (same cycle for WRITE_DELAY=1); memory updates on each rising edge while we_c=1 with a hit.
REQ-021 Write mask: mask_c = (1<<size_c)-1, truncated to 16 bits; new = (wdata_c & mask_c) | (old & ~mask_c) across bytes addr and addr+1; size 0 leaves memory unchanged; size >=16 is a full 16-bit write.
REQ-022 A write byte landing at or beyond BASE_ADDR+MEMSIZE is discarded; the in-range byte is still written.
REQ-023 Both channels writing the same byte in one cycle: channel 1 wins.
REQ-024 Read and write to the same byte in one cycle: the read samples the pre-write value.
REQ-025 oe_c=1 and we_c=1 together: memory is not written, DataRdy_c=0, cnt_c=0, and error is set to 1 until reset.
REQ-026 An X/Z value on oe or we is treated as 0.

Reset
REQ-027 reset=1 immediately forces cnt_0=cnt_1=0, pipeline stages=0, M_DataRdy=0, M_Rdata_ram=0 and error=0.
REQ-028 Memory contents are not reset and are retained across reset.
REQ-029 Reset during an outstanding read aborts it: no DataRdy pulse is produced after reset is released.

Verification
REQ-030 Defaults: ch0 writes 0xBEEF, size 16, to addr 4 -> DataRdy[0]=1 in the same cycle; a ch0 read of addr 4 one cycle later -> DataRdy[0]=1 and M_Rdata_ram[15:0]=0xBEEF on the second cycle.
REQ-031 Addr 4 holds 0xBEEF; ch1 writes 0x1234, size 8, to addr 4 -> a later read returns 0xBE34.
REQ-032 Read of addr 0x50 (miss) held for 4 cycles -> M_DataRdy=0 and read data 0 throughout; memory unchanged.
REQ-033 Both channels write addr 10 in one cycle (ch0 0x1111, ch1 0x2222) -> a read returns 0x2222; ch0 oe+we together -> error=1 until reset, memory unchanged.
REQ-034 READ_DELAY=4; reset asserted at cycle 2 of a read -> outputs are 0 immediately and no DataRdy follows; a new read after release completes in exactly 4 cycles.

Source files
------------

// File: rtl/offchip_mem_model.sv
// Dual-channel byte-addressed off-chip RAM model with fixed read/write latencies.
// Read data flows through a free-running sample pipeline; DataRdy marks the valid cycle.
module offchip_mem_model #(
  parameter int unsigned MEMSIZE     = 64,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned READ_DELAY  = 2,
  parameter int unsigned WRITE_DELAY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  Mout_oe_ram,
  input  logic [1:0]  Mout_we_ram,
  input  logic [13:0] Mout_addr_ram,
  input  logic [31:0] Mout_Wdata_ram,
  input  logic [9:0]  Mout_data_ram_size,
  output logic [31:0] M_Rdata_ram,
  output logic [1:0]  M_DataRdy,
  output logic        error
);

  localparam int unsigned AW     = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
  localparam int unsigned Stages = READ_DELAY - 1;
  localparam logic [8:0]  AddrLo = 9'(BASE_ADDR);
  localparam logic [8:0]  AddrHi = 9'(BASE_ADDR + MEMSIZE);
  localparam logic [7:0]  BaseB  = 8'(BASE_ADDR);
  localparam logic [7:0]  SizeB  = 8'(MEMSIZE);
  localparam logic [2:0]  RdLast = 3'(READ_DELAY - 1);
  localparam logic [2:0]  WrLast = 3'(WRITE_DELAY - 1);

  logic [7:0]  mem [MEMSIZE];
  logic [31:0] pipe_q [Stages];
  logic [2:0]  cnt_q [2];
  logic [2:0]  cnt_d [2];
  logic        error_q;

  logic [1:0]  oe, we, hit, hi_ok, rd_act, wr_act, conflict;
  logic [6:0]  addr [2];
  logic [4:0]  size [2];
  logic [15:0] wdata [2];
  logic [15:0] mask [2];
  logic [15:0] rdata [2];
  logic [7:0]  off [2];
  logic [7:0]  nxt [2];
  logic [7:0]  wr_lo [2];
  logic [7:0]  wr_hi [2];

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      addr[c]  = Mout_addr_ram[7*c +: 7];
      size[c]  = Mout_data_ram_size[5*c +: 5];
      wdata[c] = Mout_Wdata_ram[16*c +: 16];
      // X/Z on an enable must behave as deasserted
      oe[c]    = (Mout_oe_ram[c] === 1'b1);
      we[c]    = (Mout_we_ram[c] === 1'b1);
      hit[c]   = ({2'b00, addr[c]} >= AddrLo) && ({2'b00, addr[c]} < AddrHi);
      off[c]   = {1'b0, addr[c]} - BaseB;
      nxt[c]   = off[c] + 8'd1;
      hi_ok[c] = nxt[c] < SizeB;
      conflict[c] = oe[c] & we[c];
      rd_act[c]   = oe[c] & ~we[c] & hit[c] & ~reset;
      wr_act[c]   = we[c] & ~oe[c] & hit[c] & ~reset;
      mask[c]  = (size[c] >= 5'd16) ? 16'hFFFF : 16'((17'd1 << size[c]) - 17'd1);

      rdata[c] = 16'h0000;
      if (hit[c]) begin
        rdata[c][7:0] = mem[off[c][AW-1:0]];
        if (hi_ok[c]) rdata[c][15:8] = mem[nxt[c][AW-1:0]];
      end

      wr_lo[c] = (wdata[c][7:0] & mask[c][7:0]) | (mem[off[c][AW-1:0]] & ~mask[c][7:0]);
      wr_hi[c] = (wdata[c][15:8] & mask[c][15:8]) | (mem[nxt[c][AW-1:0]] & ~mask[c][15:8]);

      cnt_d[c] = 3'd0;
      if (rd_act[c])      cnt_d[c] = (cnt_q[c] == RdLast) ? 3'd0 : cnt_q[c] + 3'd1;
      else if (wr_act[c]) cnt_d[c] = (cnt_q[c] == WrLast) ? 3'd0 : cnt_q[c] + 3'd1;

      M_DataRdy[c] = (rd_act[c] && cnt_q[c] == RdLast) || (wr_act[c] && cnt_q[c] == WrLast);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q[0] <= 3'd0;
      cnt_q[1] <= 3'd0;
      error_q  <= 1'b0;
      for (int unsigned i = 0; i < Stages; i++) pipe_q[i] <= 32'h0;
    end else begin
      cnt_q[0]  <= cnt_d[0];
      cnt_q[1]  <= cnt_d[1];
      pipe_q[0] <= {rdata[1], rdata[0]};
      for (int unsigned i = 1; i < Stages; i++) pipe_q[i] <= pipe_q[i-1];
      if (|conflict) error_q <= 1'b1;
    end
  end

  // Memory is deliberately unreset; channel 1 is applied last so it wins a byte collision
  always_ff @(posedge clock) begin
    for (int c = 0; c < 2; c++) begin
      if (wr_act[c]) begin
        mem[off[c][AW-1:0]] <= wr_lo[c];
        if (hi_ok[c]) mem[nxt[c][AW-1:0]] <= wr_hi[c];
      end
    end
  end

  assign M_Rdata_ram = pipe_q[Stages-1];
  assign error       = error_q;

endmodule

// File: tb/tb_offchip_mem_model.sv
// Scoreboard bench for offchip_mem_model: default instance plus a READ_DELAY=4 instance.
module tb_offchip_mem_model;

  logic        clock = 1'b0;
  logic        reset, reset4;
  logic [1:0]  oe, we, oe4, we4;
  logic [13:0] addr, addr4;
  logic [31:0] wdata, wdata4;
  logic [9:0]  size, size4;
  logic [31:0] rdata, rdata4;
  logic [1:0]  rdy, rdy4;
  logic        err, err4;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0]  mem_m [64];
  logic [15:0] exp_q [$];

  offchip_mem_model dut (
    .clock(clock), .reset(reset), .Mout_oe_ram(oe), .Mout_we_ram(we),
    .Mout_addr_ram(addr), .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size),
    .M_Rdata_ram(rdata), .M_DataRdy(rdy), .error(err)
  );

  offchip_mem_model #(.READ_DELAY(4)) dut4 (
    .clock(clock), .reset(reset4), .Mout_oe_ram(oe4), .Mout_we_ram(we4),
    .Mout_addr_ram(addr4), .Mout_Wdata_ram(wdata4), .Mout_data_ram_size(size4),
    .M_Rdata_ram(rdata4), .M_DataRdy(rdy4), .error(err4)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic model_write(input int a, input logic [15:0] d, input int sz);
    logic [15:0] m;
    m = (sz >= 16) ? 16'hFFFF : 16'((32'd1 << sz) - 32'd1);
    if (a < 64) mem_m[a] = (d[7:0] & m[7:0]) | (mem_m[a] & ~m[7:0]);
    if (a + 1 < 64) mem_m[a+1] = (d[15:8] & m[15:8]) | (mem_m[a+1] & ~m[15:8]);
  endtask

  function automatic logic [15:0] model_read(input int a);
    logic [7:0] hi;
    if (a >= 64) return 16'h0000;
    hi = (a + 1 < 64) ? mem_m[a+1] : 8'h00;
    return {hi, mem_m[a]};
  endfunction

  task automatic do_write(input int ch, input int a, input logic [15:0] d, input int sz);
    we = 2'b00;
    we[ch] = 1'b1;
    addr[7*ch +: 7] = 7'(a);
    wdata[16*ch +: 16] = d;
    size[5*ch +: 5] = 5'(sz);
    #3;
    vectors++;
    if (rdy[ch] !== 1'b1) begin
      miscompares++;
      $display("FAIL write_rdy ch%0d addr %0d: got %b want 1", ch, a, rdy[ch]);
    end
    model_write(a, d, sz);
    cyc();
    we = 2'b00;
  endtask

  task automatic do_read(input int ch, input int a, input string name);
    int lat;
    logic [15:0] got, exp;
    lat = -1;
    oe = 2'b00;
    oe[ch] = 1'b1;
    addr[7*ch +: 7] = 7'(a);
    exp_q.push_back(model_read(a));
    for (int k = 0; k < 8; k++) begin
      #3;
      if (rdy[ch] === 1'b1) begin
        lat = k;
        break;
      end
      cyc();
    end
    exp = exp_q.pop_front();
    vectors++;
    if (lat != 1) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d want 1", name, lat);
    end
    if (lat >= 0) begin
      got = rdata[16*ch +: 16];
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL %s_data: got %h want %h", name, got, exp);
      end
    end
    cyc();
    oe = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b1; reset4 = 1'b1;
    oe = 0; we = 0; addr = 0; wdata = 0; size = 0;
    oe4 = 0; we4 = 0; addr4 = 0; wdata4 = 0; size4 = 0;
    cyc();
    cyc();
    vectors++;
    if ({rdy, rdata, err} !== 35'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b rdata=%h err=%b want 0", rdy, rdata, err);
    end
    vectors++;
    if ({rdy4, rdata4, err4} !== 35'h0) begin
      miscompares++;
      $display("FAIL reset_outputs4: got rdy=%b rdata=%h err=%b want 0", rdy4, rdata4, err4);
    end
    reset = 1'b0; reset4 = 1'b0;
    cyc();
  endtask

  task automatic test_write_read();
    do_write(0, 4, 16'hBEEF, 16);
    do_read(0, 4, "rd_beef");
  endtask

  task automatic test_partial();
    do_write(1, 4, 16'h1234, 8);
    do_read(0, 4, "rd_be34");
    do_write(0, 20, 16'hFFFF, 16);
    do_write(0, 20, 16'h0000, 4);
    do_write(0, 20, 16'hAAAA, 0);
    do_read(1, 20, "rd_mask4");
    do_write(1, 22, 16'h5A5A, 31);
    do_read(0, 22, "rd_size31");
  endtask

  task automatic test_miss();
    do_write(0, 16, 16'h6789, 16);
    addr = {7'h50, 7'h50};
    oe = 2'b01;
    for (int i = 0; i < 4; i++) begin
      #3;
      vectors++;
      if (rdy !== 2'b00) begin
        miscompares++;
        $display("FAIL miss_rdy cycle %0d: got %b want 00", i, rdy);
      end
      if (i > 0) begin
        vectors++;
        if (rdata !== 32'h0) begin
          miscompares++;
          $display("FAIL miss_rdata cycle %0d: got %h want 0", i, rdata);
        end
      end
      cyc();
    end
    oe = 2'b00;
    we = 2'b01;
    wdata[15:0] = 16'h0F0F;
    size[4:0] = 5'd16;
    #3;
    vectors++;
    if (rdy !== 2'b00) begin
      miscompares++;
      $display("FAIL miss_write_rdy: got %b want 00", rdy);
    end
    cyc();
    we = 2'b00;
    do_read(1, 16, "rd_no_alias");
    do_read(0, 4, "rd_after_miss");
  endtask

  task automatic test_boundary();
    do_write(0, 62, 16'h7788, 16);
    do_write(1, 63, 16'hABCD, 16);
    do_read(0, 63, "rd_last");
    do_read(1, 62, "rd_straddle");
  endtask

  task automatic test_collide();
    we = 2'b11;
    addr = {7'd10, 7'd10};
    wdata = {16'h2222, 16'h1111};
    size = {5'd16, 5'd16};
    #3;
    vectors++;
    if (rdy !== 2'b11) begin
      miscompares++;
      $display("FAIL collide_rdy: got %b want 11", rdy);
    end
    model_write(10, 16'h1111, 16);
    model_write(10, 16'h2222, 16);
    cyc();
    we = 2'b00;
    do_read(0, 10, "rd_collide");
    oe = 2'b01; we = 2'b01;
    addr[6:0] = 7'd10;
    wdata[15:0] = 16'h5555;
    #3;
    vectors++;
    if (rdy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL conflict_rdy: got %b want 0", rdy[0]);
    end
    cyc();
    oe = 2'b00; we = 2'b00;
    cyc();
    cyc();
    #3;
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL error_sticky: got %b want 1", err);
    end
    cyc();
    do_read(1, 10, "rd_conflict_unchanged");
    reset = 1'b1;
    #1;
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL error_reset: got %b want 0", err);
    end
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_rw_same();
    do_write(0, 30, 16'h1111, 16);
    oe = 2'b10; we = 2'b01;
    addr = {7'd30, 7'd30};
    wdata[15:0] = 16'h9999;
    size[4:0] = 5'd16;
    exp_q.push_back(model_read(30));
    #3;
    vectors++;
    if (rdy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL rw_write_rdy: got %b want 1", rdy[0]);
    end
    model_write(30, 16'h9999, 16);
    cyc();
    we = 2'b00;
    #3;
    begin
      logic [15:0] e;
      e = exp_q.pop_front();
      vectors++;
      if (rdy[1] !== 1'b1 || rdata[31:16] !== e) begin
        miscompares++;
        $display("FAIL rw_prewrite: got rdy=%b data=%h want 1 %h", rdy[1], rdata[31:16], e);
      end
    end
    cyc();
    oe = 2'b00;
    do_read(1, 30, "rd_postwrite");
  endtask

  task automatic test_back_to_back();
    oe = 2'b01;
    addr[6:0] = 7'd4;
    for (int i = 0; i < 6; i++) begin
      #3;
      vectors++;
      if (rdy[0] !== 1'(i % 2)) begin
        miscompares++;
        $display("FAIL hold_pulse cycle %0d: got %b want %0d", i, rdy[0], i % 2);
      end
      cyc();
    end
    oe = 2'b00;
    cyc();
  endtask

  task automatic test_read_delay4();
    int lat;
    logic [15:0] e;
    we4 = 2'b01;
    addr4[6:0] = 7'd4;
    wdata4[15:0] = 16'hCAFE;
    size4[4:0] = 5'd16;
    #3;
    vectors++;
    if (rdy4[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL rd4_write_rdy: got %b want 1", rdy4[0]);
    end
    cyc();
    we4 = 2'b00;
    oe4 = 2'b01;
    cyc();
    cyc();
    reset4 = 1'b1;
    #1;
    vectors++;
    if (rdy4 !== 2'b00 || rdata4 !== 32'h0 || err4 !== 1'b0) begin
      miscompares++;
      $display("FAIL rd4_reset_now: got rdy=%b rdata=%h err=%b want 0", rdy4, rdata4, err4);
    end
    cyc();
    reset4 = 1'b0;
    oe4 = 2'b00;
    for (int i = 0; i < 6; i++) begin
      #3;
      vectors++;
      if (rdy4 !== 2'b00) begin
        miscompares++;
        $display("FAIL rd4_aborted cycle %0d: got %b want 00", i, rdy4);
      end
      cyc();
    end
    oe4 = 2'b01;
    exp_q.push_back(16'hCAFE);
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      #3;
      if (rdy4[0] === 1'b1) begin
        lat = k;
        break;
      end
      cyc();
    end
    e = exp_q.pop_front();
    vectors++;
    if (lat != 3) begin
      miscompares++;
      $display("FAIL rd4_latency: got %0d want 3", lat);
    end
    vectors++;
    if (rdata4[15:0] !== e) begin
      miscompares++;
      $display("FAIL rd4_data: got %h want %h", rdata4[15:0], e);
    end
    cyc();
    oe4 = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_partial();
    test_miss();
    test_boundary();
    test_collide();
    test_rw_same();
    test_back_to_back();
    test_read_delay4();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
